// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IC_READ,
      LSB_READ,
      LSB_WRITE
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] IO_ADDR_HI = 2'b11;

   localparam logic HIGH  = 1'b1;
   localparam logic LOW   = 1'b0;
   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Index of the final byte of an access (N - 1).
   function automatic logic [1:0] size_last(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 2'd0;
         SIZE_HALF: return 2'd1;
         default:   return 2'd3;
      endcase
   endfunction

   function automatic logic is_io(input logic [31:0] addr);
      return addr[17:16] == IO_ADDR_HI;
   endfunction

   function automatic logic [7:0] get_byte(
      input logic [31:0] w,
      input logic [1:0]  idx
   );
      return w[{idx, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] put_byte(
      input logic [31:0] w,
      input logic [1:0]  idx,
      input logic [7:0]  b
   );
      logic [31:0] r;
      r = w;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating I-cache fetches and LSB accesses.
// Define MEMCTRL_IO_STALL_EN to honour io_buffer_full on I/O-region stores.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_flag,
   input  logic        ic_req,
   input  logic [31:0] ic_addr,
   output logic        ic_done,
   output logic [31:0] ic_data,
   input  logic        lsb_req,
   input  logic        lsb_wr,
   input  logic [1:0]  lsb_size,
   input  logic [31:0] lsb_addr,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   state_t      state;
   logic [1:0]  cnt;
   logic [1:0]  last;
   logic [2:0]  aidx;
   logic        req_v;
   logic        pend;
   logic        wr_q;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] asm_q;

   logic        stall;
   logic        rd_fin;
   logic [1:0]  nxt;
   logic [31:0] merged;

`ifdef MEMCTRL_IO_STALL_EN
   assign stall = (state == LSB_WRITE) && is_io(base) && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_buffer_full;
   assign stall     = FALSE;
`endif

   // req_v: mem_a carries a live read; pend: mem_din answers one.
   assign rd_fin = pend && (cnt == last);
   assign nxt    = cnt + 2'd1;
   assign merged = put_byte(asm_q, cnt, mem_din);
   assign mem_wr = wr_q && rdy && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         last      <= 2'd0;
         aidx      <= 3'd0;
         req_v     <= FALSE;
         pend      <= FALSE;
         wr_q      <= LOW;
         base      <= 32'd0;
         wdata     <= 32'd0;
         asm_q     <= 32'd0;
         mem_a     <= 32'd0;
         mem_dout  <= 8'd0;
         ic_done   <= LOW;
         ic_data   <= 32'd0;
         lsb_done  <= LOW;
         lsb_rdata <= 32'd0;
      end else if (!rdy) begin
         // Bytes in flight are lost; restart issue at the capture point.
         if (state == IC_READ || state == LSB_READ) begin
            req_v <= FALSE;
            pend  <= FALSE;
            aidx  <= {1'b0, cnt};
         end
      end else begin
         ic_done  <= LOW;
         lsb_done <= LOW;
         unique case (state)
            IDLE: begin
               if (!jump_flag && lsb_req && !lsb_done) begin
                  base  <= lsb_addr;
                  wdata <= lsb_wdata;
                  last  <= size_last(lsb_size);
                  mem_a <= lsb_addr;
                  cnt   <= 2'd0;
                  aidx  <= 3'd1;
                  pend  <= FALSE;
                  asm_q <= 32'd0;
                  if (lsb_wr) begin
                     state    <= LSB_WRITE;
                     mem_dout <= lsb_wdata[7:0];
                     wr_q     <= HIGH;
                  end else begin
                     state <= LSB_READ;
                     req_v <= TRUE;
                  end
               end else if (!jump_flag && ic_req && !ic_done) begin
                  state <= IC_READ;
                  base  <= ic_addr;
                  last  <= 2'd3;
                  mem_a <= ic_addr;
                  cnt   <= 2'd0;
                  aidx  <= 3'd1;
                  req_v <= TRUE;
                  pend  <= FALSE;
                  asm_q <= 32'd0;
               end
            end
            IC_READ, LSB_READ: begin
               if (jump_flag) begin
                  state <= IDLE;
                  req_v <= FALSE;
                  pend  <= FALSE;
               end else if (rd_fin) begin
                  state <= IDLE;
                  req_v <= FALSE;
                  pend  <= FALSE;
                  asm_q <= merged;
                  if (state == IC_READ) begin
                     ic_done <= HIGH;
                     ic_data <= merged;
                  end else begin
                     lsb_done  <= HIGH;
                     lsb_rdata <= merged;
                  end
               end else begin
                  if (pend) begin
                     asm_q <= merged;
                     cnt   <= nxt;
                  end
                  pend <= req_v;
                  if (aidx <= {1'b0, last}) begin
                     mem_a <= base + {29'd0, aidx};
                     aidx  <= aidx + 3'd1;
                     req_v <= TRUE;
                  end else begin
                     req_v <= FALSE;
                  end
               end
            end
            LSB_WRITE: begin
               if (!stall) begin
                  if (cnt == last) begin
                     state    <= IDLE;
                     wr_q     <= LOW;
                     lsb_done <= HIGH;
                  end else begin
                     cnt      <= nxt;
                     mem_a    <= base + {30'd0, nxt};
                     mem_dout <= get_byte(wdata, nxt);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests, monitor-side checking.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_flag;
   logic        ic_req, ic_done;
   logic [31:0] ic_addr, ic_data;
   logic        lsb_req, lsb_wr, lsb_done;
   logic [1:0]  lsb_size;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ic_pulses = 0;
   logic [31:0] exp_rdata;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } done_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  b;
      int          cyc;
   } wr_t;

   done_t icq[$];
   done_t lsq[$];
   wr_t   wq[$];

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
      .ic_data(ic_data), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
      .lsb_size(lsb_size), .lsb_addr(lsb_addr),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
      .lsb_rdata(lsb_rdata), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input logic [31:0] a);
      logic [7:0] m;
      case (a)
         32'h1000: return 8'h13;
         32'h1001: return 8'h05;
         32'h1002: return 8'hC5;
         32'h1003: return 8'h00;
         default: ;
      endcase
      m = a[7:0] * 8'd7;
      return m ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5C;
   endfunction

   // RAM returns the byte for last cycle's address.
   always @(posedge clk) mem_din <= pat(mem_a);

   function automatic logic [31:0] ld_val(input logic [31:0] a, input int n);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = pat(a + 32'(i));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      done_t d;
      wr_t   w;
      forever begin
         @(negedge clk);
         if (ic_done) begin
            ic_pulses++;
            if (icq.size() == 0) begin
               checks++; errors++;
               $display("FAIL ic_done_unexpected: got data %h expected no pulse", ic_data);
            end else begin
               d = icq.pop_front();
               chk("ic_data", ic_data, d.data);
               chk("ic_done_cycle", 32'(cyc), 32'(d.cyc));
            end
         end
         if (lsb_done) begin
            if (lsq.size() == 0) begin
               checks++; errors++;
               $display("FAIL lsb_done_unexpected: got data %h expected no pulse", lsb_rdata);
            end else begin
               d = lsq.pop_front();
               chk("lsb_rdata", lsb_rdata, d.data);
               chk("lsb_done_cycle", 32'(cyc), 32'(d.cyc));
            end
         end
         if (mem_wr) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got addr %h data %h expected none", mem_a, mem_dout);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", mem_a, w.addr);
               chk("wr_byte", {24'd0, mem_dout}, {24'd0, w.b});
               chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
         end
      end
   endtask

   task automatic ic_fetch(input logic [31:0] a, input int lat, input bit achk);
      int c0;
      c0 = cyc;
      icq.push_back('{data: ld_val(a, 4), cyc: c0 + lat});
      ic_addr = a;
      ic_req  = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (achk && k < 4) chk("ic_mem_a", mem_a, a + 32'(k));
         if (ic_done) break;
      end
      chk("ic_done_seen", {31'd0, ic_done}, 32'd1);
      ic_req = 1'b0;
      step();
   endtask

   task automatic lsb_op(input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input bit auto_wr);
      int c0, n;
      c0 = cyc;
      n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (wr && auto_wr)
         for (int i = 0; i < n; i++)
            wq.push_back('{addr: a + 32'(i), b: wd[8*i +: 8], cyc: c0 + 1 + i});
      if (!wr) exp_rdata = ld_val(a, n);
      lsq.push_back('{data: exp_rdata, cyc: c0 + lat});
      lsb_wr    = wr;
      lsb_size  = sz;
      lsb_addr  = a;
      lsb_wdata = wd;
      lsb_req   = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (lsb_done) break;
      end
      chk("lsb_done_seen", {31'd0, lsb_done}, 32'd1);
      lsb_req = 1'b0;
      step();
   endtask

   initial begin
      int c0, p0, lat;
      rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0;
      ic_req = 1'b0; ic_addr = 32'd0;
      lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00;
      lsb_addr = 32'd0; lsb_wdata = 32'd0;
      io_buffer_full = 1'b0; exp_rdata = 32'd0;
      fork monitor(); join_none
      repeat (3) step();
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_ic_done", {31'd0, ic_done}, 32'd0);
      chk("rst_ic_data", ic_data, 32'd0);
      chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
      chk("rst_lsb_rdata", lsb_rdata, 32'd0);
      rst = 1'b0;
      step();

      ic_fetch(32'h1000, 6, 1'b1);
      lsb_op(1'b1, 2'b10, 32'h2000, 32'hDEADBEEF, 5, 1'b1);
      lsb_op(1'b0, 2'b00, 32'h2003, 32'd0, 3, 1'b1);
      lsb_op(1'b0, 2'b10, 32'h2000, 32'd0, 6, 1'b1);

      // LSB wins; I-cache accepted at the edge ending lsb_done.
      fork
         ic_fetch(32'h1000, 10, 1'b0);
         lsb_op(1'b0, 2'b01, 32'h3002, 32'd0, 4, 1'b1);
      join

      // Jump in the acceptance cycle defers the request by one edge.
      fork
         ic_fetch(32'h1004, 7, 1'b0);
         begin jump_flag = 1'b1; step(); jump_flag = 1'b0; end
      join

      // Jump while the third fetch byte is on the bus.
      p0 = ic_pulses;
      ic_addr = 32'h1000;
      ic_req  = 1'b1;
      repeat (3) step();
      chk("jmp_third_addr", mem_a, 32'h1002);
      jump_flag = 1'b1;
      ic_req    = 1'b0;
      step();
      jump_flag = 1'b0;
      repeat (8) step();
      chk("jmp_no_ic_done", 32'(ic_pulses - p0), 32'd0);

      fork
         lsb_op(1'b1, 2'b10, 32'h2100, 32'hCAFEF00D, 5, 1'b1);
         begin step(); step(); jump_flag = 1'b1; step(); jump_flag = 1'b0; end
      join

      lsb_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0, 4, 1'b1);

      c0 = cyc;
`ifdef MEMCTRL_IO_STALL_EN
      wq.push_back('{addr: 32'h0003_0000, b: 8'h41, cyc: c0 + 4});
      lat = 5;
`else
      wq.push_back('{addr: 32'h0003_0000, b: 8'h41, cyc: c0 + 1});
      lat = 2;
`endif
      fork
         lsb_op(1'b1, 2'b00, 32'h0003_0000, 32'h41, lat, 1'b0);
         begin step(); io_buffer_full = 1'b1; repeat (3) step(); io_buffer_full = 1'b0; end
      join

      // rdy low for two cycles while the third store byte is presented.
      c0 = cyc;
      wq.push_back('{addr: 32'h2200, b: 8'h44, cyc: c0 + 1});
      wq.push_back('{addr: 32'h2201, b: 8'h33, cyc: c0 + 2});
      wq.push_back('{addr: 32'h2202, b: 8'h22, cyc: c0 + 5});
      wq.push_back('{addr: 32'h2203, b: 8'h11, cyc: c0 + 6});
      fork
         lsb_op(1'b1, 2'b10, 32'h2200, 32'h11223344, 7, 1'b0);
         begin repeat (3) step(); rdy = 1'b0; repeat (2) step(); rdy = 1'b1; end
      join

      // Reset in the middle of a word fetch.
      ic_addr = 32'h1000;
      ic_req  = 1'b1;
      repeat (3) step();
      rst    = 1'b1;
      ic_req = 1'b0;
      step();
      chk("midrst_mem_a", mem_a, 32'd0);
      chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("midrst_ic_done", {31'd0, ic_done}, 32'd0);
      chk("midrst_ic_data", ic_data, 32'd0);
      chk("midrst_lsb_rdata", lsb_rdata, 32'd0);
      rst = 1'b0;
      exp_rdata = 32'd0;
      step();

      ic_fetch(32'h1000, 6, 1'b1);
      repeat (4) step();
      chk("icq_drained", 32'(icq.size()), 32'd0);
      chk("lsq_drained", 32'(lsq.size()), 32'd0);
      chk("wq_drained", 32'(wq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
